seed_round_key_buffer: RTL and testbench

Stores the 16 SEED round-key pairs (Ki,0, Ki,1) produced by the key schedule, then serves them to the round datapath in forward order for encryption or reverse order for decryption. It is the read side of the key schedule's output: the key schedule writes pairs once per key, and the round engine reads them once per block. A loaded key set can be replayed for any number of blocks until it is cleared.

---
 rtl/seed_round_key_buffer_pkg.sv | 16 +
 rtl/seed_round_key_buffer_regfile.sv | 35 +++
 rtl/seed_round_key_buffer.sv | 117 +++++++++++
 tb/tb_seed_round_key_buffer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seed_round_key_buffer_pkg.sv
// Shared types and sizes for the SEED round-key buffer.
package seed_pkg;

  localparam int unsigned SEED_ROUNDS = 16;
  localparam int unsigned SEED_KW     = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILLING = 2'd1,
    LOADED  = 2'd2,
    SERVING = 2'd3
  } kbuf_state_t;

  typedef logic [3:0] round_idx_t;

endpackage

// File: rtl/seed_round_key_buffer_regfile.sv
// Round-key pair storage: synchronous write, asynchronous read, one-cycle zeroize.
module seed_key_regfile
  import seed_pkg::*;
#(
  parameter int unsigned DEPTH = SEED_ROUNDS,
  parameter int unsigned KW    = SEED_KW
) (
  input  logic          clk,
  input  logic          i_zero,
  input  logic          i_we,
  input  round_idx_t    i_waddr,
  input  logic [KW-1:0] i_wk0,
  input  logic [KW-1:0] i_wk1,
  input  round_idx_t    i_raddr,
  output logic [KW-1:0] o_rk0,
  output logic [KW-1:0] o_rk1
);

  logic [2*KW-1:0] r_mem [DEPTH];

  // Zeroize wipes every entry in one cycle and overrides any write.
  always_ff @(posedge clk) begin
    if (i_zero) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= {i_wk1, i_wk0};
    end
  end

  assign o_rk0 = r_mem[i_raddr][KW-1:0];
  assign o_rk1 = r_mem[i_raddr][2*KW-1:KW];

endmodule

// File: rtl/seed_round_key_buffer.sv
// Fill-once / replay-many buffer for the 16 SEED round-key pairs.
module seed_round_key_buffer
  import seed_pkg::*;
#(
  parameter int unsigned ROUNDS = SEED_ROUNDS,
  parameter int unsigned KW     = SEED_KW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          key_clear,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [KW-1:0] wr_k0,
  input  logic [KW-1:0] wr_k1,
  input  logic          rd_start,
  input  logic          rd_decrypt,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [KW-1:0] rd_k0,
  output logic [KW-1:0] rd_k1,
  output logic [3:0]    rd_round,
  output logic          rd_last,
  output logic          full
);

  localparam round_idx_t LAST = round_idx_t'(ROUNDS - 1);

  kbuf_state_t r_state, w_state_nxt;
  round_idx_t  r_wptr, w_wptr_nxt;
  round_idx_t  r_rptr, w_rptr_nxt;
  logic        r_dir, w_dir_nxt;
  logic        w_we;
  logic        w_wr_fire;
  logic        w_last;
  logic        w_zero;

  assign w_zero    = !rst_n || key_clear;
  assign wr_ready  = rst_n && !key_clear && (r_state == IDLE || r_state == FILLING);
  assign w_wr_fire = wr_valid && wr_ready;
  assign w_last    = (r_dir ? (r_rptr == '0) : (r_rptr == LAST));

  assign rd_valid  = (r_state == SERVING);
  assign rd_last   = rd_valid && w_last;
  assign rd_round  = r_rptr;
  assign full      = (r_state == LOADED) || (r_state == SERVING);

  // Next-state, pointer and write-enable decode.
  always_comb begin
    w_state_nxt = r_state;
    w_wptr_nxt  = r_wptr;
    w_rptr_nxt  = r_rptr;
    w_dir_nxt   = r_dir;
    w_we        = 1'b0;
    unique case (r_state)
      IDLE, FILLING: begin
        if (w_wr_fire) begin
          w_we = 1'b1;
          // The final write leaves wptr parked so it never wraps.
          if (r_wptr == LAST) begin
            w_state_nxt = LOADED;
          end else begin
            w_wptr_nxt  = r_wptr + 1'b1;
            w_state_nxt = FILLING;
          end
        end
      end
      LOADED: begin
        if (rd_start) begin
          w_dir_nxt   = rd_decrypt;
          w_rptr_nxt  = rd_decrypt ? LAST : '0;
          w_state_nxt = SERVING;
        end
      end
      SERVING: begin
        if (rd_ready) begin
          if (w_last) begin
            w_state_nxt = LOADED;
          end else begin
            w_rptr_nxt = r_dir ? (r_rptr - 1'b1) : (r_rptr + 1'b1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and pointer registers; clear/reset beats every other input.
  always_ff @(posedge clk) begin
    if (w_zero) begin
      r_state <= IDLE;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_dir   <= w_dir_nxt;
    end
  end

  seed_key_regfile #(
    .DEPTH (ROUNDS),
    .KW    (KW)
  ) u_regfile (
    .clk     (clk),
    .i_zero  (w_zero),
    .i_we    (w_we),
    .i_waddr (r_wptr),
    .i_wk0   (wr_k0),
    .i_wk1   (wr_k1),
    .i_raddr (r_rptr),
    .o_rk0   (rd_k0),
    .o_rk1   (rd_k1)
  );

endmodule

// File: tb/tb_seed_round_key_buffer.sv
// Self-checking bench for seed_round_key_buffer against a key-array model.
module tb_seed_round_key_buffer;

  logic        clk;
  logic        rst_n;
  logic        key_clear;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_k0;
  logic [31:0] wr_k1;
  logic        rd_start;
  logic        rd_decrypt;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_k0;
  logic [31:0] rd_k1;
  logic [3:0]  rd_round;
  logic        rd_last;
  logic        full;

  int checks = 0;
  int errors = 0;

  logic [31:0] mk0 [16];
  logic [31:0] mk1 [16];

  seed_round_key_buffer #(
    .ROUNDS (16),
    .KW     (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_clear  (key_clear),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_k0      (wr_k0),
    .wr_k1      (wr_k1),
    .rd_start   (rd_start),
    .rd_decrypt (rd_decrypt),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_k0      (rd_k0),
    .rd_k1      (rd_k1),
    .rd_round   (rd_round),
    .rd_last    (rd_last),
    .full       (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_model_ab();
    for (int i = 0; i < 16; i++) begin
      mk0[i] = 32'hA000_0000 + 32'(i);
      mk1[i] = 32'hB000_0000 + 32'(i);
    end
  endtask

  // Write the model's 16 pairs; optionally pulse rd_start mid-fill and on the last write.
  task automatic do_fill(input bit start_noise);
    for (int i = 0; i < 16; i++) begin
      wr_valid   = 1'b1;
      wr_k0      = mk0[i];
      wr_k1      = mk1[i];
      rd_start   = start_noise && (i == 5 || i == 15);
      rd_decrypt = 1'b0;
      #1;
      checks++;
      if (wr_ready !== 1'b1) begin errors++; $display("FAIL fill_wr_ready i=%0d got %b exp 1", i, wr_ready); end
      checks++;
      if (full !== 1'b0) begin errors++; $display("FAIL fill_full i=%0d got %b exp 0", i, full); end
      checks++;
      if (rd_valid !== 1'b0) begin errors++; $display("FAIL fill_rd_valid i=%0d got %b exp 0", i, rd_valid); end
      tick();
    end
    wr_valid = 1'b0;
    rd_start = 1'b0;
    #1;
    checks++;
    if (full !== 1'b1) begin errors++; $display("FAIL loaded_full got %b exp 1", full); end
    checks++;
    if (wr_ready !== 1'b0) begin errors++; $display("FAIL loaded_wr_ready got %b exp 0", wr_ready); end
    checks++;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL loaded_rd_valid got %b exp 0", rd_valid); end
  endtask

  // One read pass. mode 0: ready always; 1: ready 0,0,1 repeating; 2: random ready.
  task automatic serve_pass(input bit dir, input int mode, input bit noise);
    int n;
    int c;
    int idx;
    rd_start   = 1'b1;
    rd_decrypt = dir;
    rd_ready   = 1'b0;
    wr_valid   = noise;
    wr_k0      = 32'hDEAD_BEEF;
    wr_k1      = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL start_rd_valid got %b exp 0", rd_valid); end
    tick();
    rd_start = 1'b0;
    n = 0;
    c = 0;
    while (n < 16 && c < 300) begin
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (c % 3 == 2);
        default: rd_ready = 1'($urandom_range(1));
      endcase
      rd_start   = noise && (c == 3);
      rd_decrypt = ~dir;
      #1;
      idx = dir ? 15 - n : n;
      checks++;
      if (rd_valid !== 1'b1) begin errors++; $display("FAIL serve_valid n=%0d got %b exp 1", n, rd_valid); end
      checks++;
      if (rd_round !== 4'(idx)) begin errors++; $display("FAIL serve_round n=%0d got %0d exp %0d", n, rd_round, idx); end
      checks++;
      if (rd_k0 !== mk0[idx]) begin errors++; $display("FAIL serve_k0 n=%0d got %h exp %h", n, rd_k0, mk0[idx]); end
      checks++;
      if (rd_k1 !== mk1[idx]) begin errors++; $display("FAIL serve_k1 n=%0d got %h exp %h", n, rd_k1, mk1[idx]); end
      checks++;
      if (rd_last !== (n == 15)) begin errors++; $display("FAIL serve_last n=%0d got %b exp %b", n, rd_last, (n == 15)); end
      checks++;
      if (full !== 1'b1 || wr_ready !== 1'b0) begin errors++; $display("FAIL serve_full_wrready got %b%b exp 10", full, wr_ready); end
      if (rd_ready) n++;
      tick();
      c++;
    end
    rd_ready = 1'b0;
    rd_start = 1'b0;
    wr_valid = 1'b0;
    checks++;
    if (n != 16) begin errors++; $display("FAIL serve_timeout handshakes got %0d exp 16", n); end
    if (mode == 0) begin
      checks++;
      if (c != 16) begin errors++; $display("FAIL serve_cycles got %0d exp 16", c); end
    end
    #1;
    checks++;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL pass_end_valid got %b exp 0", rd_valid); end
    checks++;
    if (full !== 1'b1) begin errors++; $display("FAIL pass_end_full got %b exp 1", full); end
  endtask

  task automatic pulse_clear();
    key_clear = 1'b1;
    #1;
    checks++;
    if (wr_ready !== 1'b0) begin errors++; $display("FAIL clear_wr_ready got %b exp 0", wr_ready); end
    tick();
    key_clear = 1'b0;
    #1;
    checks++;
    if (wr_ready !== 1'b1 || full !== 1'b0 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL clear_state got wr_ready=%b full=%b rd_valid=%b exp 1 0 0", wr_ready, full, rd_valid);
    end
    checks++;
    if (rd_k0 !== 32'h0 || rd_k1 !== 32'h0 || rd_round !== 4'd0) begin
      errors++; $display("FAIL clear_data got %h %h r%0d exp 0 0 r0", rd_k0, rd_k1, rd_round);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready_in got %b exp 0", wr_ready); end
    checks++;
    if (rd_valid !== 1'b0 || full !== 1'b0 || rd_last !== 1'b0) begin
      errors++; $display("FAIL reset_flags got v=%b f=%b l=%b exp 0 0 0", rd_valid, full, rd_last);
    end
    checks++;
    if (rd_k0 !== 32'h0 || rd_k1 !== 32'h0 || rd_round !== 4'd0) begin
      errors++; $display("FAIL reset_data got %h %h r%0d exp 0 0 r0", rd_k0, rd_k1, rd_round);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready_after got %b exp 1", wr_ready); end
  endtask

  task automatic test_forward();
    set_model_ab();
    do_fill(1'b0);
    serve_pass(1'b0, 0, 1'b0);
  endtask

  task automatic test_reverse();
    serve_pass(1'b1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    serve_pass(1'b0, 1, 1'b0);
    serve_pass(1'b1, 2, 1'b0);
  endtask

  task automatic test_ignored();
    pulse_clear();
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    #1;
    checks++;
    if (rd_valid !== 1'b0 || full !== 1'b0 || wr_ready !== 1'b1) begin
      errors++; $display("FAIL idle_start got v=%b f=%b wr=%b exp 0 0 1", rd_valid, full, wr_ready);
    end
    set_model_ab();
    do_fill(1'b1);
    wr_valid = 1'b1;
    wr_k0    = 32'h1234_5678;
    wr_k1    = 32'h8765_4321;
    tick();
    tick();
    wr_valid = 1'b0;
    serve_pass(1'b0, 2, 1'b1);
    serve_pass(1'b1, 0, 1'b0);
  endtask

  task automatic test_clear_mid_fill();
    pulse_clear();
    set_model_ab();
    for (int i = 0; i < 7; i++) begin
      wr_valid = 1'b1;
      wr_k0    = mk0[i];
      wr_k1    = mk1[i];
      tick();
    end
    wr_k0 = 32'hDEAD_BEEF;
    wr_k1 = 32'hDEAD_BEEF;
    pulse_clear();
    wr_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mk0[i] = 32'h0;
      mk1[i] = 32'h0;
    end
    do_fill(1'b0);
    serve_pass(1'b0, 0, 1'b0);
  endtask

  task automatic test_clear_mid_serve();
    int c;
    pulse_clear();
    set_model_ab();
    do_fill(1'b0);
    rd_start   = 1'b1;
    rd_decrypt = 1'b0;
    tick();
    rd_start = 1'b0;
    rd_ready = 1'b1;
    c = 0;
    while (rd_round !== 4'd5 && c < 40) begin
      tick();
      c++;
    end
    rd_ready = 1'b0;
    checks++;
    if (rd_round !== 4'd5 || rd_valid !== 1'b1 || rd_k0 !== 32'hA000_0005) begin
      errors++; $display("FAIL mid_serve_reach got r%0d v=%b k0=%h exp r5 1 a0000005", rd_round, rd_valid, rd_k0);
    end
    checks++;
    if (c != 5) begin errors++; $display("FAIL mid_serve_cycles got %0d exp 5", c); end
    pulse_clear();
  endtask

  task automatic test_random();
    for (int p = 0; p < 3; p++) begin
      pulse_clear();
      for (int i = 0; i < 16; i++) begin
        mk0[i] = $urandom;
        mk1[i] = $urandom;
      end
      do_fill(1'($urandom_range(1)));
      for (int q = 0; q < 2; q++) begin
        serve_pass(1'($urandom_range(1)), 2, 1'($urandom_range(1)));
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    key_clear  = 1'b0;
    wr_valid   = 1'b0;
    wr_k0      = '0;
    wr_k1      = '0;
    rd_start   = 1'b0;
    rd_decrypt = 1'b0;
    rd_ready   = 1'b0;
    test_reset();
    test_forward();
    test_reverse();
    test_backpressure();
    test_ignored();
    test_clear_mid_fill();
    test_clear_mid_serve();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
